wb_slave_regfile: RTL and testbench

// Wishbone classic-cycle responder (slave) with a small byte-writable register file.

---
 rtl/wb_slave_regfile_pkg.sv | 23 ++
 rtl/wb_slave_bytereg.sv | 24 ++
 rtl/wb_slave_regfile.sv | 119 +++++++++++
 tb/tb_wb_slave_regfile.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_slave_regfile_pkg.sv
// Shared FSM state and termination-type encodings for the Wishbone register-file slave.
package wb_slave_regfile_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_TERM = 2'd2;

    localparam logic [1:0] TERM_ACK = 2'd0;
    localparam logic [1:0] TERM_ERR = 2'd1;
    localparam logic [1:0] TERM_RTY = 2'd2;

    // Busy outranks a bad address: a busy slave never inspects the request.
    function automatic logic [1:0] term_select(input logic busy, input logic legal);
        if (busy) begin
            return TERM_RTY;
        end
        if (!legal) begin
            return TERM_ERR;
        end
        return TERM_ACK;
    endfunction

endpackage

// File: rtl/wb_slave_bytereg.sv
// One data-width register with independent per-byte write enables.
module wb_slave_bytereg #(
    parameter int unsigned dwidth = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [dwidth/8-1:0]   byte_en,
    input  logic [dwidth-1:0]     wdata,
    output logic [dwidth-1:0]     value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else begin
            for (int unsigned b = 0; b < dwidth / 8; b++) begin
                if (byte_en[b]) begin
                    value[b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone classic-cycle slave: captured request, programmable wait states,
// ack/err/rty termination and a byte-writable register file.
module wb_slave_regfile
    import wb_slave_regfile_pkg::*;
#(
    parameter int unsigned        dwidth      = 32,
    parameter int unsigned        awidth      = 32,
    parameter int unsigned        nregs       = 8,
    parameter logic [awidth-1:0]  base_adr    = '0,
    parameter int unsigned        wait_states = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [awidth-1:0]         wb_adr_i,
    input  logic [dwidth-1:0]         wb_dat_i,
    output logic [dwidth-1:0]         wb_dat_o,
    input  logic [dwidth/8-1:0]       wb_sel_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_rty_o,
    input  logic                      busy_i,
    output logic [nregs*dwidth-1:0]   regs_o
);

    localparam int unsigned       nbytes    = dwidth / 8;
    localparam int unsigned       lsb_w     = $clog2(nbytes);
    localparam int unsigned       idx_w     = $clog2(nregs);
    localparam logic [awidth-1:0] span      = awidth'(nregs * nbytes);
    localparam logic [awidth-1:0] lsb_mask  = awidth'(nbytes - 1);
    localparam logic [3:0]        wait_load = 4'(wait_states - 1);

    logic [1:0]          state;
    logic [1:0]          term;
    logic [3:0]          wait_cnt;
    logic                we_q;
    logic [nbytes-1:0]   sel_q;
    logic [dwidth-1:0]   dat_q;
    logic [idx_w-1:0]    idx_q;
    logic [awidth-1:0]   offset;
    logic                legal;
    logic                wr_en;
    logic [dwidth-1:0]   reg_q [nregs];

    // base_adr is span-aligned, so one unsigned offset compare covers both bounds
    // and the offset's low bits carry the same alignment as the address.
    always_comb begin
        offset = wb_adr_i - base_adr;
        legal  = (offset < span) && ((offset & lsb_mask) == '0);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state    <= ST_IDLE;
            term     <= TERM_ACK;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            dat_q    <= '0;
            idx_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        we_q  <= wb_we_i;
                        sel_q <= wb_sel_i;
                        dat_q <= wb_dat_i;
                        idx_q <= idx_w'(offset >> lsb_w);
                        term  <= term_select(busy_i, legal);
                        if (wait_states == 0) begin
                            state <= ST_TERM;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= wait_load;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wb_cyc_i) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= ST_TERM;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_TERM: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wb_ack_o = (state == ST_TERM) && (term == TERM_ACK);
    assign wb_err_o = (state == ST_TERM) && (term == TERM_ERR);
    assign wb_rty_o = (state == ST_TERM) && (term == TERM_RTY);
    assign wr_en    = wb_ack_o && we_q;
    assign wb_dat_o = wb_ack_o ? reg_q[idx_q] : '0;

    for (genvar k = 0; k < nregs; k++) begin : g_reg
        logic [nbytes-1:0] byte_en;

        assign byte_en = (wr_en && (idx_q == idx_w'(k))) ? sel_q : '0;

        wb_slave_bytereg #(
            .dwidth (dwidth)
        ) u_reg (
            .clk     (wb_clk_i),
            .rst_n   (wb_rst_i),
            .byte_en (byte_en),
            .wdata   (dat_q),
            .value   (reg_q[k])
        );

        assign regs_o[k*dwidth +: dwidth] = reg_q[k];
    end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Directed bench for wb_slave_regfile: one slave with 1 wait state, one with 3.
module tb_wb_slave_regfile;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   adr;
    logic [31:0]   wdat;
    logic [3:0]    sel;
    logic          we;
    logic          cyc1;
    logic          cyc3;
    logic          stb;
    logic          busy;
    logic          use3;

    logic [31:0]   dat1, dat3;
    logic          ack1, err1, rty1, ack3, err3, rty3;
    logic [255:0]  regs1, regs3;

    logic          t_ack, t_err, t_rty;
    logic [31:0]   t_dat;

    int unsigned   checks = 0;
    int unsigned   errors = 0;

    logic [2:0]    res;
    logic [31:0]   rd;
    int            lat;

    always #5 clk = ~clk;

    wb_slave_regfile #(
        .dwidth      (32),
        .awidth      (32),
        .nregs       (8),
        .base_adr    (BASE),
        .wait_states (1)
    ) u_dut1 (
        .wb_clk_i (clk),   .wb_rst_i (rst_n),  .wb_adr_i (adr),   .wb_dat_i (wdat),
        .wb_dat_o (dat1),  .wb_sel_i (sel),    .wb_we_i  (we),    .wb_cyc_i (cyc1),
        .wb_stb_i (stb),   .wb_ack_o (ack1),   .wb_err_o (err1),  .wb_rty_o (rty1),
        .busy_i   (busy),  .regs_o   (regs1)
    );

    wb_slave_regfile #(
        .dwidth      (32),
        .awidth      (32),
        .nregs       (8),
        .base_adr    (BASE),
        .wait_states (3)
    ) u_dut3 (
        .wb_clk_i (clk),   .wb_rst_i (rst_n),  .wb_adr_i (adr),   .wb_dat_i (wdat),
        .wb_dat_o (dat3),  .wb_sel_i (sel),    .wb_we_i  (we),    .wb_cyc_i (cyc3),
        .wb_stb_i (stb),   .wb_ack_o (ack3),   .wb_err_o (err3),  .wb_rty_o (rty3),
        .busy_i   (busy),  .regs_o   (regs3)
    );

    assign t_ack = use3 ? ack3 : ack1;
    assign t_err = use3 ? err3 : err1;
    assign t_rty = use3 ? rty3 : rty1;
    assign t_dat = use3 ? dat3 : dat1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] flat(input logic [31:0] r0, input logic [31:0] r1,
                                          input logic [31:0] r2, input logic [31:0] r3);
        return {128'h0, r3, r2, r1, r0};
    endfunction

    // One master cycle; res = {ack,err,rty} at termination, lat = edges from request to termination.
    task automatic bus(input logic on3, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic w,
                       output logic [2:0] r, output logic [31:0] q, output int n);
        use3 = on3;
        adr  = a;
        wdat = d;
        sel  = s;
        we   = w;
        stb  = 1'b1;
        if (on3) cyc3 = 1'b1;
        else     cyc1 = 1'b1;
        n = 0;
        r = 3'b000;
        q = '0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (t_ack || t_err || t_rty) break;
        end
        r = {t_ack, t_err, t_rty};
        q = t_dat;
        cyc1 = 1'b0;
        cyc3 = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        @(posedge clk);
        #1;
        check("pulse_end", {253'h0, t_ack, t_err, t_rty}, 256'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        adr = '0; wdat = '0; sel = '0; we = 1'b0;
        cyc1 = 1'b0; cyc3 = 1'b0; stb = 1'b0; busy = 1'b0; use3 = 1'b0;

        #12;
        check("rst_term", {253'h0, ack1, err1, rty1}, 256'h0);
        check("rst_dat", {224'h0, dat1}, 256'h0);
        check("rst_regs", regs1, 256'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single-word write then compare
        bus(1'b0, BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b1, res, rd, lat);
        check("wr1_term", {253'h0, res}, 256'b100);
        check("wr1_lat", 256'(lat), 256'd2);
        check("wr1_regs_o", {224'h0, regs1[63:32]}, {224'h0, 32'hDEAD_BEEF});
        bus(1'b0, BASE + 32'h4, 32'h0, 4'hF, 1'b0, res, rd, lat);
        check("rd1_term", {253'h0, res}, 256'b100);
        check("rd1_lat", 256'(lat), 256'd2);
        check("rd1_dat", {224'h0, rd}, {224'h0, 32'hDEAD_BEEF});

        // partial byte write over all-ones
        bus(1'b0, BASE, 32'hFFFF_FFFF, 4'hF, 1'b1, res, rd, lat);
        bus(1'b0, BASE, 32'h1122_3344, 4'b0101, 1'b1, res, rd, lat);
        check("part_term", {253'h0, res}, 256'b100);
        bus(1'b0, BASE, 32'h0, 4'hF, 1'b0, res, rd, lat);
        check("part_dat", {224'h0, rd}, {224'h0, 32'hFF22_FF44});

        // address boundaries
        bus(1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0, res, rd, lat);
        check("oor_hi_term", {253'h0, res}, 256'b010);
        check("oor_hi_dat", {224'h0, rd}, 256'h0);
        bus(1'b0, BASE - 32'h4, 32'h7777_7777, 4'hF, 1'b1, res, rd, lat);
        check("oor_lo_term", {253'h0, res}, 256'b010);
        bus(1'b0, BASE + 32'h2, 32'h7777_7777, 4'hF, 1'b1, res, rd, lat);
        check("misalign_term", {253'h0, res}, 256'b010);
        bus(1'b0, BASE + 32'h1C, 32'h0, 4'hF, 1'b0, res, rd, lat);
        check("last_reg_term", {253'h0, res}, 256'b100);
        check("err_regs", regs1, flat(32'hFF22_FF44, 32'hDEAD_BEEF, 32'h0, 32'h0));

        // busy -> retry, then accepted
        busy = 1'b1;
        bus(1'b0, BASE, 32'h5, 4'hF, 1'b1, res, rd, lat);
        check("busy_term", {253'h0, res}, 256'b001);
        check("busy_regs", regs1, flat(32'hFF22_FF44, 32'hDEAD_BEEF, 32'h0, 32'h0));
        busy = 1'b0;
        bus(1'b0, BASE, 32'h5, 4'hF, 1'b1, res, rd, lat);
        check("unbusy_term", {253'h0, res}, 256'b100);
        check("unbusy_regs", regs1, flat(32'h5, 32'hDEAD_BEEF, 32'h0, 32'h0));

        // sel=0 write acks without change
        bus(1'b0, BASE + 32'h4, 32'h0, 4'h0, 1'b1, res, rd, lat);
        check("sel0_term", {253'h0, res}, 256'b100);
        check("sel0_regs", regs1, flat(32'h5, 32'hDEAD_BEEF, 32'h0, 32'h0));

        // three wait states, then abort mid-WAIT
        bus(1'b1, BASE + 32'h8, 32'hA5A5_A5A5, 4'hF, 1'b1, res, rd, lat);
        check("ws3_term", {253'h0, res}, 256'b100);
        check("ws3_lat", 256'(lat), 256'd4);
        use3 = 1'b1;
        adr = BASE + 32'h8; wdat = 32'h1234_5678; sel = 4'hF; we = 1'b1;
        cyc3 = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
        res = 3'b000;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            res = res | {t_ack, t_err, t_rty};
        end
        check("abort_term", {253'h0, res}, 256'h0);
        check("abort_regs", regs3, flat(32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0));
        bus(1'b1, BASE + 32'h8, 32'h0, 4'hF, 1'b0, res, rd, lat);
        check("post_abort_lat", 256'(lat), 256'd4);
        check("post_abort_dat", {224'h0, rd}, {224'h0, 32'hA5A5_A5A5});

        // asynchronous reset during WAIT discards the in-flight write
        use3 = 1'b0;
        adr = BASE + 32'hC; wdat = 32'hCAFE_F00D; sel = 4'hF; we = 1'b1;
        cyc1 = 1'b1; stb = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_term", {253'h0, ack1, err1, rty1}, 256'h0);
        check("arst_regs1", regs1, 256'h0);
        check("arst_regs3", regs3, 256'h0);
        cyc1 = 1'b0; stb = 1'b0; we = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus(1'b0, BASE + 32'hC, 32'h0, 4'hF, 1'b0, res, rd, lat);
        check("arst_rd_term", {253'h0, res}, 256'b100);
        check("arst_rd_dat", {224'h0, rd}, 256'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
